note_seq_ctrl: RTL and testbench

//  Parametrised record/playback sequencer controller for the note-memory datapath.

---
 rtl/note_seq_pkg.sv | 18 +
 rtl/note_seq_if.sv | 36 +++
 rtl/note_rate_divider.sv | 31 +++
 rtl/note_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_note_seq_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/note_seq_pkg.sv
// Shared types and width helpers for the note record/playback sequencer.
package note_seq_pkg;

  // Sequencer states; the fourth 2-bit code is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  localparam int STATE_W = 2;

  // Note counter width for a given memory depth: must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/note_seq_if.sv
// Button inputs, RAM/tone-generator outputs and debug state of the sequencer.
// Buttons are active-low levels; wr_en and note_tick are single-cycle strobes,
// there is no backpressure on any signal. ADDR_W must equal $clog2(DEPTH) of
// the connected note_seq_ctrl.
interface note_seq_if #(
  parameter int ADDR_W = 4
) ();
  import note_seq_pkg::*;

  logic              load_n;
  logic              play_n;
  logic              stop_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              ld_note;
  logic              ld_play;
  logic              note_tick;
  logic [ADDR_W:0]   count;
  logic              full;
  state_t            dbg_state;

  // Controller side
  modport master (
    input  load_n, play_n, stop_n,
    output wr_en, wr_addr, rd_addr, ld_note, ld_play, note_tick, count, full,
    output dbg_state
  );

  // Board / RAM side
  modport slave (
    output load_n, play_n, stop_n,
    input  wr_en, wr_addr, rd_addr, ld_note, ld_play, note_tick, count, full,
    input  dbg_state
  );
endinterface

// File: rtl/note_rate_divider.sv
// Note-period divider: down-counter that ticks when it reaches 0 and reloads
// TICKS-1. Held at TICKS-1 while not running or when restarted, so the first
// period after a start is a full TICKS cycles long.
module note_rate_divider #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic run,
  output logic tick
);
  localparam int CW = $clog2(TICKS);
  localparam logic [CW-1:0] RELOAD = CW'(TICKS - 1);

  logic [CW-1:0] cnt_q;

  // Count down while running, reload on terminal count or when idle
  always_ff @(posedge clk) begin
    if (reset || restart || !run) begin
      cnt_q <= RELOAD;
    end else if (cnt_q == '0) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign tick = run && (cnt_q == '0);

endmodule

// File: rtl/note_seq_ctrl.sv
// Record/playback sequencer controller for the note-memory datapath.
// Counts notes recorded with the load button and then steps the read address
// through them, one note per TICKS_PER_NOTE cycles.
// Optional feature: define NOTE_SEQ_LOOP_EN to loop playback until stop/reset;
// without it playback returns to IDLE after the last note.
module note_seq_ctrl
  import note_seq_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int TICKS_PER_NOTE = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  note_seq_if.master  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_en_q, wr_en_d;
  logic              tick;
  logic              full;
  logic              last_note;
  logic              div_run;
  logic              div_restart;
  logic              ld_note, ld_play;

  assign full      = (count_q == DEPTH_C);
  // count is at least 1 whenever PLAY is active, so count-1 never wraps there
  assign last_note = ({1'b0, rd_addr_q} == (count_q - CNT_W'(1)));

  assign div_run     = (state_q == PLAY);
  assign div_restart = (state_q != PLAY) && (state_d == PLAY);

  note_rate_divider #(
    .TICKS (TICKS_PER_NOTE)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .restart (div_restart),
    .run     (div_run),
    .tick    (tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: load beats play beats stop in IDLE; stop beats tick in PLAY
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!bus.load_n) begin
          state_d = LOAD;
        end else if (!bus.play_n && (count_q != '0)) begin
          state_d = PLAY;
        end
      end
      LOAD: begin
        if (bus.load_n) begin
          state_d = IDLE;
        end
      end
      PLAY: begin
        if (!bus.stop_n) begin
          state_d = IDLE;
        end else if (tick && last_note) begin
`ifdef NOTE_SEQ_LOOP_EN
          state_d = PLAY;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    ld_note = 1'b0;
    ld_play = 1'b0;
    case (state_q)
      LOAD:    ld_note = 1'b1;
      PLAY:    ld_play = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: note count, write strobe/address, read address
  always_comb begin
    count_d   = count_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_en_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // Clear only when neither load nor a valid play takes priority
        if (bus.load_n && !(!bus.play_n && (count_q != '0)) && !bus.stop_n) begin
          count_d = '0;
        end
      end
      LOAD: begin
        // The note is committed on button release, at the old count
        if (bus.load_n && !full) begin
          wr_en_d   = 1'b1;
          wr_addr_d = count_q[ADDR_W-1:0];
          count_d   = count_q + CNT_W'(1);
        end
      end
      PLAY: begin
        if (!bus.stop_n) begin
          rd_addr_d = '0;
        end else if (tick) begin
          if (last_note) begin
            rd_addr_d = '0;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
      end
      default: rd_addr_d = '0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.ld_note   = ld_note;
  assign bus.ld_play   = ld_play;
  assign bus.note_tick = tick;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Bench for note_seq_ctrl with DEPTH=4, TICKS_PER_NOTE=4. Handles both
// builds (NOTE_SEQ_LOOP_EN defined or not).
module tb_note_seq_ctrl;
  import note_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int TICKS = 4;
  localparam int NVEC  = 18;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [1:0] exp_q[$];

  note_seq_if #(.ADDR_W(2)) bus ();

  note_seq_ctrl #(
    .DEPTH          (DEPTH),
    .TICKS_PER_NOTE (TICKS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply buttons on the falling edge, then sample just after the next rising edge
  task automatic cyc(input logic l, input logic p, input logic s);
    @(negedge clk);
    bus.load_n = l;
    bus.play_n = p;
    bus.stop_n = s;
    @(posedge clk);
    #1;
  endtask

  // One load press/release; expects a write at exp_addr
  task automatic press_load(input logic [1:0] exp_addr);
    exp_q.push_back(exp_addr);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
  endtask

  // ---------------- scoreboard: every write strobe must match exp_q ----------------
  always @(posedge clk) begin
    #1;
    if (bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_write unexpected write wr_addr=%0d expected none", bus.wr_addr);
      end else begin
        chk("sb_wr_addr", 0, 32'(bus.wr_addr), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       load_n;
    logic       play_n;
    logic       stop_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic       ld_note;
    logic       ld_play;
    logic [2:0] count;
    logic       full;
  } vec_t;

  vec_t vecs[NVEC];

  initial begin
    checks   = 0;
    failures = 0;

    //            l     p     s     we    wa    ln    lp    cnt   full
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 3'd1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 3'd1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 3'd1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 3'd2, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 3'd2, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 3'd3, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 3'd3, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 3'd3, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 3'd4, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 3'd4, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 3'd4, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 3'd0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 3'd1, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0};

    // Writes the table produces, in order
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);

    // ---- reset held two cycles ----
    reset      = 1'b1;
    bus.load_n = 1'b1;
    bus.play_n = 1'b1;
    bus.stop_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en",   0, 32'(bus.wr_en),     32'd0);
    chk("rst_wr_addr", 0, 32'(bus.wr_addr),   32'd0);
    chk("rst_rd_addr", 0, 32'(bus.rd_addr),   32'd0);
    chk("rst_ld_note", 0, 32'(bus.ld_note),   32'd0);
    chk("rst_ld_play", 0, 32'(bus.ld_play),   32'd0);
    chk("rst_tick",    0, 32'(bus.note_tick), 32'd0);
    chk("rst_count",   0, 32'(bus.count),     32'd0);
    chk("rst_full",    0, 32'(bus.full),      32'd0);
    chk("rst_state",   0, 32'(bus.dbg_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;

    // ---- table: loads, saturation, clear, play ignored when empty, priority ----
    for (int i = 0; i < NVEC; i++) begin
      cyc(vecs[i].load_n, vecs[i].play_n, vecs[i].stop_n);
      chk("vec_wr_en",   i, 32'(bus.wr_en),   32'(vecs[i].wr_en));
      chk("vec_wr_addr", i, 32'(bus.wr_addr), 32'(vecs[i].wr_addr));
      chk("vec_ld_note", i, 32'(bus.ld_note), 32'(vecs[i].ld_note));
      chk("vec_ld_play", i, 32'(bus.ld_play), 32'(vecs[i].ld_play));
      chk("vec_count",   i, 32'(bus.count),   32'(vecs[i].count));
      chk("vec_full",    i, 32'(bus.full),    32'(vecs[i].full));
      chk("vec_rd_addr", i, 32'(bus.rd_addr), 32'd0);
    end

    // ---- reset while in LOAD, released together with the button: no write ----
    press_load(2'd0);
    press_load(2'd1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("rl_in_load", 0, 32'(bus.ld_note), 32'd1);
    @(negedge clk);
    bus.load_n = 1'b1;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    chk("rl_wr_en",   0, 32'(bus.wr_en),     32'd0);
    chk("rl_count",   0, 32'(bus.count),     32'd0);
    chk("rl_ld_note", 0, 32'(bus.ld_note),   32'd0);
    chk("rl_state",   0, 32'(bus.dbg_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;

    // ---- record three notes, then play them ----
    press_load(2'd0);
    press_load(2'd1);
    press_load(2'd2);
    chk("pl_count", 0, 32'(bus.count), 32'd3);

    for (int k = 0; k < 12; k++) begin
      if (k == 0) cyc(1'b1, 1'b0, 1'b1);
      else        cyc(1'b1, 1'b1, 1'b1);
      chk("pl_ld_play", k, 32'(bus.ld_play),   32'd1);
      chk("pl_rd_addr", k, 32'(bus.rd_addr),   32'(k / 4));
      chk("pl_tick",    k, 32'(bus.note_tick), 32'((k % 4) == 3));
    end
    cyc(1'b1, 1'b1, 1'b1);
`ifdef NOTE_SEQ_LOOP_EN
    chk("eos_ld_play", 0, 32'(bus.ld_play), 32'd1);
    chk("eos_rd_addr", 0, 32'(bus.rd_addr), 32'd0);
    chk("eos_tick",    0, 32'(bus.note_tick), 32'd0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("eos_rd_hold", 0, 32'(bus.rd_addr), 32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("eos_stop_lp", 0, 32'(bus.ld_play), 32'd0);
    chk("eos_stop_rd", 0, 32'(bus.rd_addr), 32'd0);
    chk("eos_count",   0, 32'(bus.count),   32'd3);
`else
    chk("eos_ld_play", 0, 32'(bus.ld_play),   32'd0);
    chk("eos_rd_addr", 0, 32'(bus.rd_addr),   32'd0);
    chk("eos_state",   0, 32'(bus.dbg_state), 32'(IDLE));
    chk("eos_count",   0, 32'(bus.count),     32'd3);
`endif

    // ---- stop on the same cycle as the tick with rd_addr=1 ----
    cyc(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k == 0) cyc(1'b1, 1'b0, 1'b1);
      else        cyc(1'b1, 1'b1, 1'b1);
    end
    chk("st_pre_tick", 0, 32'(bus.note_tick), 32'd1);
    chk("st_pre_rd",   0, 32'(bus.rd_addr),   32'd1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("st_ld_play", 0, 32'(bus.ld_play),   32'd0);
    chk("st_rd_addr", 0, 32'(bus.rd_addr),   32'd0);
    chk("st_count",   0, 32'(bus.count),     32'd3);
    chk("st_tick",    0, 32'(bus.note_tick), 32'd0);
    chk("st_state",   0, 32'(bus.dbg_state), 32'(IDLE));
    cyc(1'b1, 1'b1, 1'b1);
    chk("st_count_kept", 0, 32'(bus.count), 32'd3);

    // ---- clear in IDLE, then play is ignored ----
    cyc(1'b1, 1'b1, 1'b0);
    chk("clr_count", 0, 32'(bus.count), 32'd0);
    chk("clr_full",  0, 32'(bus.full),  32'd0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("clr_ld_play", 0, 32'(bus.ld_play),   32'd0);
    chk("clr_state",   0, 32'(bus.dbg_state), 32'(IDLE));
    cyc(1'b1, 1'b1, 1'b1);
    chk("clr_ld_play2", 0, 32'(bus.ld_play), 32'd0);

    // ---- every expected write must have been seen ----
    chk("sb_drained", 0, 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
